// File: rtl/pattern_scan_ctrl_if.sv
// Word-wide valid/ready channel between a producer and pattern_scan_ctrl.
// The producer drives the master side and the controller drives in_ready.
interface pattern_scan_ctrl_if #(
  parameter int DATA_W = 8
);
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_last;
  logic              in_ready;

  modport master (output in_valid, output in_data, output in_last, input in_ready);
  modport slave  (input in_valid, input in_data, input in_last, output in_ready);
endinterface

// File: rtl/pattern_scan_ctrl.sv
// Serialises accepted words MSB-first and scans the bit stream for a programmable
// 2..PAT_MAX-bit pattern, counting matches per job and pulsing done at job end.
module pattern_scan_ctrl #(
  parameter int DATA_W  = 8,
  parameter int PAT_MAX = 8,
  parameter int LEN_W   = 4,
  parameter int CNT_W   = 8
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [PAT_MAX-1:0]  cfg_pattern,
  input  logic [LEN_W-1:0]    cfg_len,
  input  logic                cfg_overlap,
  input  logic                start,
  pattern_scan_ctrl_if.slave  in_if,
  output logic                busy,
  output logic                match_pulse,
  output logic [CNT_W-1:0]    match_count,
  output logic                done,
  output logic                err_cfg
);

  localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [LEN_W-1:0] PAT_MAX_L = LEN_W'(PAT_MAX);
  localparam logic [LEN_W-1:0] LEN_MIN_L = LEN_W'(2);

  typedef enum logic [1:0] {IDLE, WAIT, SHIFT, DONE} state_t;

  state_t              state_q;
  logic [PAT_MAX-1:0]  pat_q;
  logic [LEN_W-1:0]    len_q;
  logic                ovl_q;
  logic [DATA_W-1:0]   data_q;
  logic                last_q;
  logic [IDX_W-1:0]    idx_q;
  logic [PAT_MAX-1:0]  hist_q;
  logic [LEN_W-1:0]    fill_q;
  logic [CNT_W-1:0]    count_q;
  logic                match_q;
  logic                done_q;
  logic                err_q;

  logic [PAT_MAX-1:0]  hist_d;
  logic [LEN_W-1:0]    fill_d;
  logic [PAT_MAX-1:0]  len_mask;
  logic                hit;
  logic                cfg_ok;

  // Next detector history/fill for the bit being shifted in, and whether it completes a match.
  always_comb begin
    hist_d   = {hist_q[PAT_MAX-2:0], data_q[idx_q]};
    fill_d   = (fill_q >= PAT_MAX_L) ? PAT_MAX_L : fill_q + 1'b1;
    len_mask = '0;
    for (int i = 0; i < PAT_MAX; i++) begin
      if (LEN_W'(i) < len_q) len_mask[i] = 1'b1;
    end
    hit    = (fill_d >= len_q) && ((hist_d & len_mask) == (pat_q & len_mask));
    cfg_ok = (cfg_len >= LEN_MIN_L) && (cfg_len <= PAT_MAX_L);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      pat_q   <= '0;
      len_q   <= '0;
      ovl_q   <= 1'b0;
      data_q  <= '0;
      last_q  <= 1'b0;
      idx_q   <= '0;
      hist_q  <= '0;
      fill_q  <= '0;
      count_q <= '0;
      match_q <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      match_q <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            if (cfg_ok) begin
              pat_q   <= cfg_pattern;
              len_q   <= cfg_len;
              ovl_q   <= cfg_overlap;
              count_q <= '0;
              hist_q  <= '0;
              fill_q  <= '0;
              state_q <= WAIT;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        WAIT: begin
          if (in_if.in_valid) begin
            data_q  <= in_if.in_data;
            last_q  <= in_if.in_last;
            idx_q   <= IDX_W'(DATA_W - 1);
            state_q <= SHIFT;
          end
        end
        SHIFT: begin
          // Non-overlapping mode forgets the history length so the next match needs fresh bits.
          hist_q <= hist_d;
          fill_q <= (hit && !ovl_q) ? '0 : fill_d;
          if (hit) begin
            match_q <= 1'b1;
            if (!(&count_q)) count_q <= count_q + 1'b1;
          end
          if (idx_q == '0) begin
            state_q <= last_q ? DONE : WAIT;
          end else begin
            idx_q <= idx_q - 1'b1;
          end
        end
        DONE: begin
          done_q  <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_if.in_ready = (state_q == WAIT);
  assign busy           = (state_q != IDLE);
  assign match_pulse    = match_q;
  assign match_count    = count_q;
  assign done           = done_q;
  assign err_cfg        = err_q;

endmodule
